tdc_diff_accum: RTL
===================

TDC_DIFF_ACCUM -- requirements
Module: tdc_diff_accum

Interface
REQ-001 SHALL have parameter AVG_LOG2, default 4, meaning log2 of samples per averaging window (N = 2^AVG_LOG2; legal range 1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning result FIFO entries (power of 2, minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_data, input, 20 bits: signed two's-complement difference sample.
REQ-006 SHALL have port i_dval, input, 1 bit: producer strobe; idles high and drops low for the interval after each new sample.
REQ-007 SHALL have port i_clr, input, 1 bit: synchronous window, FIFO and overflow clear.
REQ-008 SHALL have port i_ready, input, 1 bit: downstream accepts the head result.
REQ-009 SHALL have port o_data, output, 20 bits: signed window average at the FIFO head.
REQ-010 SHALL have port o_valid, output, 1 bit: FIFO not empty.
REQ-011 SHALL have port o_level, output, $clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-012 SHALL have port o_ovf, output, 1 bit: sticky flag, set when a result was dropped.

Function
REQ-013 SHALL detect a sample on a 1->0 transition of i_dval (previous-value register low-true edge); a low level held for any number of cycles SHALL count once.
REQ-014 SHALL capture i_data in the cycle the edge is detected; the sample enters the accumulator at that clock edge.
REQ-015 SHALL use a signed accumulator of 20+AVG_LOG2 bits and a counter of AVG_LOG2 bits; the window sum SHALL never overflow.
REQ-016 On the N-th sample: result = (acc + sample) arithmetic-shifted right by AVG_LOG2 (floor toward minus infinity), truncated to 20 bits; pushed to the FIFO at the same edge; acc and counter return to 0 at that edge.
REQ-017 o_valid SHALL rise in the cycle after the N-th sample's capture cycle when the FIFO was empty; latency = 1 cycle.
REQ-018 The FIFO SHALL be show-ahead: o_data equals the head entry whenever o_valid=1; pop occurs when o_valid & i_ready.
REQ-019 Push with FIFO full and no pop: result dropped, o_ovf set, contents unchanged.
REQ-020 Push with FIFO full and a simultaneous pop: both occur, no drop, o_level unchanged.
REQ-021 A pop on an empty FIFO (i_ready=1, o_valid=0) SHALL have no effect.
REQ-022 i_clr=1 SHALL zero acc, counter, FIFO and o_ovf at the next edge; a sample edge in the same cycle SHALL be discarded, and i_clr SHALL win over push and pop.
REQ-023 The counter SHALL wrap N-1 -> 0 with no idle cycle; back-to-back edges (every 2 cycles) SHALL be sustained.

Reset
REQ-024 rst SHALL set o_valid=0, o_level=0, o_ovf=0, o_data=0, acc=0, counter=0, FIFO pointers=0, and the i_dval previous-value register=1.
REQ-025 rst asserted mid-window SHALL discard the partial window; the first edge after release SHALL be sample 0 of a new window.

Configuration
REQ-026 With macro TDC_DIFF_MINMAX_EN defined: ports o_min and o_max (20-bit signed) SHALL exist.
REQ-027 Under TDC_DIFF_MINMAX_EN, o_min and o_max SHALL carry the per-window extremes, stored in the FIFO alongside the average (entry width 60) and reset to 0.
REQ-028 Without TDC_DIFF_MINMAX_EN: the o_min/o_max ports and the min/max logic SHALL be absent, and the FIFO entry width SHALL be 20.

Structure
REQ-029 Package tdc_pkg SHALL hold DIFF_W=20, the diff_t signed typedef and the FIFO entry struct (avg, plus min/max under the macro).
REQ-030 Storage SHALL be a sub-module tdc_sfifo, a synchronous show-ahead FIFO with parameters width and depth and outputs full, empty and level; the edge detect and accumulator SHALL stay in the top module.

Verification (bench: AVG_LOG2=2, FIFO_DEPTH=4)
REQ-031 Reset with i_dval held 1 for 50 cycles -> o_valid=0, o_level=0, o_ovf=0.
REQ-032 Edges with data 100, 102, 98, 104 -> a single result 101 (0x00065), o_valid one cycle after the 4th capture; i_dval held low 16 cycles per sample -> still one count each.
REQ-033 Edges with data -3, -2, -2, -2 (sum -9) -> result -3 (0xFFFFD).
REQ-034 i_ready=0 with 5 windows -> o_level=4 and o_ovf=1, then the first 4 results pop in order; repeat with a pop in the 5th push cycle -> no drop, o_ovf stays 0.
REQ-035 Two samples of 50, then i_clr, then four samples of 8 -> a single result 8; i_clr coincident with an edge -> that sample is not counted.
REQ-036 With TDC_DIFF_MINMAX_EN: data 5, -7, 3, 1 -> o_data=0, o_min=-7, o_max=5.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types for the TDC difference averager.
// Optional build macro TDC_DIFF_MINMAX_EN adds per-window min/max to each FIFO entry.
package tdc_pkg;

    localparam int DIFF_W = 20;

    typedef logic signed [DIFF_W-1:0] diff_t;

    typedef struct packed {
`ifdef TDC_DIFF_MINMAX_EN
        diff_t max;
        diff_t min;
`endif
        diff_t avg;
    } fifo_entry_t;

endpackage

// File: rtl/tdc_sfifo.sv
// Synchronous show-ahead FIFO: rdata shows the head entry while not empty, zero otherwise.
// Push when full is accepted only if a pop happens in the same cycle.
module tdc_sfifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [LW-1:0]    level_q;
    logic             do_pop;
    logic             do_push;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign do_pop  = pop & ~empty & ~rst & ~clr;
    assign do_push = push & (~full | do_pop) & ~rst & ~clr;
    assign rdata   = empty ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/tdc_diff_accum.sv
// Averages windows of 2^AVG_LOG2 signed difference samples (taken on i_dval falling edges)
// into a show-ahead result FIFO. Define TDC_DIFF_MINMAX_EN for o_min/o_max per window.
module tdc_diff_accum
    import tdc_pkg::*;
#(
    parameter int AVG_LOG2   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIFF_W-1:0]           i_data,
    input  logic                        i_dval,
    input  logic                        i_clr,
    input  logic                        i_ready,
    output logic [DIFF_W-1:0]           o_data,
    output logic                        o_valid,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_ovf
`ifdef TDC_DIFF_MINMAX_EN
    ,
    output logic [DIFF_W-1:0]           o_min,
    output logic [DIFF_W-1:0]           o_max
`endif
);

    localparam int ACC_W = DIFF_W + AVG_LOG2;

    logic                    dval_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [AVG_LOG2-1:0]     cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] sum_w;
    logic signed [ACC_W-1:0] avg_w;
    diff_t                   sample;
    logic                    take;
    logic                    last;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    fifo_entry_t             wentry;
    fifo_entry_t             rentry;

    assign sample = i_data;
    // A clear in the edge cycle swallows that sample.
    assign take   = dval_q & ~i_dval & ~i_clr;
    assign last   = &cnt_q;
    assign push   = take & last;
    assign pop    = o_valid & i_ready;
    assign sum_w  = acc_q + {{AVG_LOG2{sample[DIFF_W-1]}}, sample};
    assign avg_w  = sum_w >>> AVG_LOG2;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q | (push & full & ~pop);
        if (take) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_w;
                cnt_d = cnt_q + AVG_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dval_q <= 1'b1;
        end else begin
            dval_q <= i_dval;
        end
        if (rst || i_clr) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef TDC_DIFF_MINMAX_EN
    diff_t min_q, max_q;
    diff_t win_min, win_max;

    // First sample of a window seeds both extremes.
    assign win_min = (cnt_q == '0 || sample < min_q) ? sample : min_q;
    assign win_max = (cnt_q == '0 || sample > max_q) ? sample : max_q;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            min_q <= '0;
            max_q <= '0;
        end else if (take) begin
            min_q <= win_min;
            max_q <= win_max;
        end
    end

    always_comb begin
        wentry     = '0;
        wentry.avg = avg_w[DIFF_W-1:0];
        wentry.min = win_min;
        wentry.max = win_max;
    end

    assign o_min = rentry.min;
    assign o_max = rentry.max;
`else
    always_comb begin
        wentry     = '0;
        wentry.avg = avg_w[DIFF_W-1:0];
    end
`endif

    tdc_sfifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (i_clr),
        .push  (push),
        .pop   (pop),
        .wdata (wentry),
        .rdata (rentry),
        .full  (full),
        .empty (empty),
        .level (o_level)
    );

    assign o_data  = rentry.avg;
    assign o_valid = ~empty;
    assign o_ovf   = ovf_q;

endmodule
